// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the multiplier accumulator slice.
//   PROD_W       width of one multiplier product (s5..s0)
//   macc_state_t accumulator FSM state encoding
package mult_pkg;

    localparam int PROD_W = 6;

    typedef enum logic {
        ACCUM,
        DONE
    } macc_state_t;

endpackage

// File: rtl/mult_accumulator_if.sv
// mult_accumulator_if: product input handshake plus result output handshake.
//   in_valid/in_ready/prod              upstream beat from the multiplier
//   out_valid/out_ready/acc_out/overflow downstream finished result
//   master: producer/consumer side, slave: the accumulator
interface mult_accumulator_if #(
    parameter int ACC_W = 8
) ();
    import mult_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              overflow;

    modport master (
        output in_valid, prod, out_ready,
        input  in_ready, out_valid, acc_out, overflow
    );

    modport slave (
        input  in_valid, prod, out_ready,
        output in_ready, out_valid, acc_out, overflow
    );

endinterface

// File: rtl/beat_counter.sv
// beat_counter: modulo-COUNT_N counter of accepted beats.
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   clr  synchronous restart to zero
//   inc  count one beat this cycle
//   last inc on the final beat of a group (cnt == COUNT_N-1)
module beat_counter #(
    parameter int COUNT_N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int CNT_W = $clog2(COUNT_N + 1);

    logic [CNT_W-1:0] cnt;

    assign last = inc & (cnt == CNT_W'(COUNT_N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mult_accumulator.sv
// mult_accumulator: sums COUNT_N multiplier products and hands the sum downstream.
//   clk    clock, rising edge
//   rst    synchronous active-high reset (highest priority)
//   clear  synchronous abort: drops partial sum and any pending result
//   bus    slave side of mult_accumulator_if (product in, result out)
//
// state | meaning
// ACCUM | taking products, in_ready=1, out_valid=0
// DONE  | result held on acc_out/overflow until out_ready, in_ready=0
module mult_accumulator
    import mult_pkg::*;
#(
    parameter int ACC_W   = 8,
    parameter int COUNT_N = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    mult_accumulator_if.slave   bus
);

    macc_state_t      state;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             accept;
    logic             last;
    logic [ACC_W:0]   sum;

    // in_ready_r mirrors state, so acceptance never looks at out_ready
    assign accept = bus.in_valid & in_ready_r;

    // extra MSB captures the carry out of the accumulator width
    assign sum = {1'b0, acc} + (ACC_W + 1)'(bus.prod);

    beat_counter #(
        .COUNT_N (COUNT_N)
    ) u_beat_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .inc  (accept),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state       <= ACCUM;
            acc         <= '0;
            ovf         <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else if (state == ACCUM) begin
            if (accept) begin
                acc <= sum[ACC_W-1:0];
                ovf <= ovf | sum[ACC_W];
                if (last) begin
                    state       <= DONE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b1;
                end
            end
        end else begin
            if (bus.out_ready) begin
                state       <= ACCUM;
                acc         <= '0;
                ovf         <= 1'b0;
                in_ready_r  <= 1'b1;
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.acc_out   = acc;
    assign bus.overflow  = ovf;

endmodule

// File: tb/tb_mult_accumulator.sv
// Two accumulators (COUNT_N=4 and COUNT_N=6) share one stimulus stream.
// A reference model tracks accepted products as plain integer sums; finished
// results go into a per-instance queue and a negedge monitor compares them.
module tb_mult_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [5:0] prod;
    logic       out_ready;
    bit         mon_en = 1'b0;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mult_accumulator_if #(.ACC_W(8)) bus4 ();
    mult_accumulator_if #(.ACC_W(8)) bus6 ();

    assign bus4.in_valid  = in_valid;
    assign bus4.prod      = prod;
    assign bus4.out_ready = out_ready;
    assign bus6.in_valid  = in_valid;
    assign bus6.prod      = prod;
    assign bus6.out_ready = out_ready;

    mult_accumulator #(.ACC_W(8), .COUNT_N(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus4)
    );

    mult_accumulator #(.ACC_W(8), .COUNT_N(6)) u_dut6 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus6)
    );

    // reference model: running integer sum, beat count, result-pending flag
    int   n_of [2] = '{4, 6};
    int   cnt_m [2];
    int   sum_m [2];
    bit   pend_m [2];
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];

    initial begin
        for (int k = 0; k < 2; k++) begin
            cnt_m[k]  = 0;
            sum_m[k]  = 0;
            pend_m[k] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || clear) begin
                cnt_m[k]  = 0;
                sum_m[k]  = 0;
                pend_m[k] = 1'b0;
                if (k == 0) q0.delete(); else q1.delete();
            end else if (pend_m[k]) begin
                if (out_ready) pend_m[k] = 1'b0;
            end else if (in_valid) begin
                sum_m[k] = sum_m[k] + int'(prod);
                cnt_m[k] = cnt_m[k] + 1;
                if (cnt_m[k] == n_of[k]) begin
                    if (k == 0) q0.push_back({sum_m[k] >= 256, 8'(sum_m[k] % 256)});
                    else        q1.push_back({sum_m[k] >= 256, 8'(sum_m[k] % 256)});
                    pend_m[k] = 1'b1;
                    cnt_m[k]  = 0;
                    sum_m[k]  = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int k, input logic ov, input logic ir,
                             input logic [7:0] acc, input logic of);
        logic [8:0] exp;
        bit         have;
        string      tag;
        tag  = $sformatf("dut_n%0d", n_of[k]);
        have = 1'b0;
        exp  = '0;
        check({tag, " out_valid"}, {8'd0, ov}, {8'd0, pend_m[k]});
        check({tag, " in_ready"}, {8'd0, ir}, {8'd0, ~pend_m[k]});
        if (ov) begin
            if (k == 0) begin
                have = q0.size() > 0;
                if (have) exp = q0[0];
            end else begin
                have = q1.size() > 0;
                if (have) exp = q1[0];
            end
            if (!have) begin
                vectors++;
                errors++;
                $display("FAIL %s result: got %0d expected no result", tag, {of, acc});
            end else begin
                check({tag, " result"}, {of, acc}, exp);
                if (out_ready && !rst && !clear) begin
                    if (k == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
            end
        end else begin
            check({tag, " partial"}, {of, acc},
                  {sum_m[k] >= 256, 8'(sum_m[k] % 256)});
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_dut(0, bus4.out_valid, bus4.in_ready, bus4.acc_out, bus4.overflow);
            check_dut(1, bus6.out_valid, bus6.in_ready, bus6.acc_out, bus6.overflow);
        end
    end

    task automatic step(input logic v, input logic [5:0] p, input logic o,
                        input logic c, input logic r);
        in_valid  = v;
        prod      = p;
        out_ready = o;
        clear     = c;
        rst       = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit [6:0] gap_pat;
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        prod      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        mon_en = 1'b1;
        step(0, 0, 1, 0, 1);

        // four beats of 7*7, then two more to finish the six-beat instance
        repeat (4) step(1, 49, 1, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        repeat (2) step(1, 49, 1, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        step(1, 49, 1, 0, 0);
        step(0, 0, 1, 1, 0);

        // backpressure while in_valid keeps pushing
        repeat (12) step(1, 5, 0, 0, 0);
        repeat (2) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);

        // gaps in in_valid
        gap_pat = 7'b1011001;
        for (int i = 0; i < 7; i++) step(gap_pat[i], 6'(i + 1), 1, 0, 0);
        repeat (4) step(1, 7, 1, 0, 0);
        step(0, 0, 1, 1, 0);

        // clear mid-group, then a full group, then clear while result is held
        step(1, 10, 1, 0, 0);
        step(1, 20, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        repeat (4) step(1, 1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0);

        // reset together with clear and a valid beat
        repeat (2) step(1, 9, 1, 0, 0);
        step(1, 9, 1, 1, 1);
        step(0, 0, 1, 0, 0);

        // back-to-back stream
        repeat (24) step(1, 3, 1, 0, 0);

        // random traffic
        repeat (500) begin
            step($urandom_range(0, 3) != 0, 6'($urandom_range(0, 63)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 149) == 0);
        end
        repeat (4) step(0, 0, 1, 0, 0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
